// File: rtl/div_seq_if.sv
// Handshake/result bundle for the sequential restoring divider div_seq.
// The master side starts operations; the slave side (the divider) returns results.
interface div_seq_if #(
  parameter int unsigned N = 4
);
  logic         ld;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] rq;
  logic [N-1:0] rr;
  logic         dz;

  modport master (
    output ld, a, b,
    input  busy, done, rq, rr, dz
  );

  modport slave (
    input  ld, a, b,
    output busy, done, rq, rr, dz
  );
endinterface

// File: rtl/div_seq.sv
// Sequential restoring divider: one quotient bit per clock, N clocks per divide.
// Optional macro DIV_ZERO_DET_EN: short-circuits b==0 to a 1-clock result with dz=1.
module div_seq #(
  parameter int unsigned N = 4
) (
  input  logic       clk,
  input  logic       rst,
  div_seq_if.slave   bus
);

  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_n;
  logic [N-1:0]  rq_q, rq_n;
  logic [N-1:0]  rr_q, rr_n;
  logic [N-1:0]  d_q, d_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          busy_q, busy_n;
  logic          done_q, done_n;
`ifdef DIV_ZERO_DET_EN
  logic          dz_q, dz_n;
`endif

  // Restoring step operands: partial remainder shifted left with the next dividend bit.
  logic [N:0] t;
  logic [N:0] dx;
  logic       ge;

  assign t  = {rr_q, rq_q[N-1]};
  assign dx = {1'b0, d_q};
  assign ge = (t >= dx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rq_q    <= '0;
      rr_q    <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DIV_ZERO_DET_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      rq_q    <= rq_n;
      rr_q    <= rr_n;
      d_q     <= d_n;
      cnt_q   <= cnt_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
`ifdef DIV_ZERO_DET_EN
      dz_q    <= dz_n;
`endif
    end
  end

  always_comb begin
    state_n = state_q;
    rq_n    = rq_q;
    rr_n    = rr_q;
    d_n     = d_q;
    cnt_n   = cnt_q;
    busy_n  = busy_q;
    done_n  = done_q;
`ifdef DIV_ZERO_DET_EN
    dz_n    = dz_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (bus.ld) begin
`ifdef DIV_ZERO_DET_EN
          if (bus.b == '0) begin
            // Zero divisor: skip the loop and present the natural all-ones result.
            state_n = DONE;
            rq_n    = '1;
            rr_n    = bus.a;
            d_n     = bus.b;
            cnt_n   = '0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            dz_n    = 1'b1;
          end else begin
            state_n = RUN;
            rq_n    = bus.a;
            rr_n    = '0;
            d_n     = bus.b;
            cnt_n   = '0;
            busy_n  = 1'b1;
            done_n  = 1'b0;
            dz_n    = 1'b0;
          end
`else
          state_n = RUN;
          rq_n    = bus.a;
          rr_n    = '0;
          d_n     = bus.b;
          cnt_n   = '0;
          busy_n  = 1'b1;
          done_n  = 1'b0;
`endif
        end
      end

      RUN: begin
        // Shift the new quotient bit in; subtract only when the divisor fits.
        rq_n  = N'({rq_q, ge});
        rr_n  = ge ? N'(t - dx) : t[N-1:0];
        cnt_n = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_n = DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.rq   = rq_q;
  assign bus.rr   = rr_q;
`ifdef DIV_ZERO_DET_EN
  assign bus.dz   = dz_q;
`else
  assign bus.dz   = 1'b0;
`endif

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: stimulus pushes expected quotient/remainder/latency,
// a monitor pops and compares whenever the divider presents a result.
module tb_div_seq;

  localparam int unsigned N = 4;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
    int           lat;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  bit           inflight;
  int           acc_cyc;
  bit           have_last;
  logic [N-1:0] last_rq;
  logic [N-1:0] last_rr;

  div_seq_if #(.N(N)) bus ();

  div_seq #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference model: plain integer division, zero divisor gives all-ones / dividend.
  function automatic exp_t model(input logic [N-1:0] ai, input logic [N-1:0] bi);
    exp_t e;
    e.a = ai;
    e.b = bi;
    if (bi == 0) begin
      e.q = {N{1'b1}};
      e.r = ai;
`ifdef DIV_ZERO_DET_EN
      e.dz  = 1'b1;
      e.lat = 1;
`else
      e.dz  = 1'b0;
      e.lat = int'(N);
`endif
    end else begin
      e.q   = N'(int'(ai) / int'(bi));
      e.r   = N'(int'(ai) % int'(bi));
      e.dz  = 1'b0;
      e.lat = int'(N);
    end
    return e;
  endfunction

  task automatic issue(input logic [N-1:0] ai, input logic [N-1:0] bi, input bit push);
    @(posedge clk);
    #1;
    bus.ld = 1'b1;
    bus.a  = ai;
    bus.b  = bi;
    if (push) exp_q.push_back(model(ai, bi));
    @(posedge clk);
    #1;
    bus.ld = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL wait_done: timeout, done stayed 0 (cycle %0d)", cyc);
    end
  endtask

  // Monitor: tracks accepted loads and checks the result when done is presented.
  initial begin
    exp_t e;
    inflight  = 1'b0;
    have_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        inflight  = 1'b0;
        have_last = 1'b0;
      end else begin
        if (inflight && bus.done) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: rq=%0d rr=%0d with empty scoreboard", bus.rq, bus.rr);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("rq a=%0d b=%0d", e.a, e.b), int'(bus.rq), int'(e.q));
            chk($sformatf("rr a=%0d b=%0d", e.a, e.b), int'(bus.rr), int'(e.r));
            chk($sformatf("dz a=%0d b=%0d", e.a, e.b), int'(bus.dz), int'(e.dz));
            chk($sformatf("latency a=%0d b=%0d", e.a, e.b), cyc - acc_cyc, e.lat);
            chk("busy_at_done", int'(bus.busy), 0);
            if (e.b != 0) begin
              chk("identity a==q*b+r", int'(bus.rq) * int'(e.b) + int'(bus.rr), int'(e.a));
              chk("remainder<b", int'(bus.rr < e.b), 1);
            end
          end
          inflight  = 1'b0;
          have_last = 1'b1;
          last_rq   = bus.rq;
          last_rr   = bus.rr;
        end else if (inflight) begin
          chk("busy_during_run", int'(bus.busy), 1);
        end else if (bus.done && have_last) begin
          chk("rq_hold_in_done", int'(bus.rq), int'(last_rq));
          chk("rr_hold_in_done", int'(bus.rr), int'(last_rr));
        end
        if (bus.ld && !bus.busy) begin
          inflight = 1'b1;
          acc_cyc  = cyc + 1;
        end
      end
    end
  end

  initial begin
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    cyc    = 0;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    bus.ld = 1'b0;
    bus.a  = '0;
    bus.b  = '0;
    #2 rst = 1'b0;
    #1;
    chk("reset busy", int'(bus.busy), 0);
    chk("reset done", int'(bus.done), 0);
    chk("reset rq", int'(bus.rq), 0);
    chk("reset rr", int'(bus.rr), 0);
    chk("reset dz", int'(bus.dz), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Directed cases
    issue(4'd13, 4'd3, 1'b1);  wait_done();
    issue(4'd8,  4'd4, 1'b1);  wait_done();
    issue(4'd15, 4'd1, 1'b1);  wait_done();
    issue(4'd3,  4'd7, 1'b1);  wait_done();

    // ld during RUN must be ignored
    issue(4'd9, 4'd2, 1'b1);
    #1;
    bus.ld = 1'b1;
    bus.a  = 4'd5;
    bus.b  = 4'd5;
    @(posedge clk);
    #1 bus.ld = 1'b0;
    wait_done();

    // Reset mid-RUN aborts the operation
    issue(4'd11, 4'd3, 1'b0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("midrun reset busy", int'(bus.busy), 0);
    chk("midrun reset done", int'(bus.done), 0);
    chk("midrun reset rq", int'(bus.rq), 0);
    chk("midrun reset rr", int'(bus.rr), 0);
    chk("midrun reset dz", int'(bus.dz), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    issue(4'd6, 4'd4, 1'b1);   wait_done();

    // Zero divisor
    issue(4'd10, 4'd0, 1'b1);  wait_done();
    issue(4'd7,  4'd0, 1'b1);  wait_done();
    issue(4'd13, 4'd3, 1'b1);  wait_done();

    // Exhaustive sweep of nonzero divisors
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 1; bi < 16; bi++) begin
        issue(N'(ai), N'(bi), 1'b1);
        wait_done();
      end
    end

    // Random operands, zero divisor included, with a few random idle gaps
    for (int k = 0; k < 60; k++) begin
      ra = N'($urandom_range(15, 0));
      rb = N'($urandom_range(15, 0));
      issue(ra, rb, 1'b1);
      wait_done();
      repeat ($urandom_range(2, 0)) @(posedge clk);
    end

    repeat (4) @(posedge clk);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
